// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared state/error types and checksum helper for the UART packet receiver.
package uart_pkt_pkg;

    typedef enum logic [1:0] {IDLE, DATA, CHK} pkt_state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_TO   = 2'd1,
        ERR_CHK  = 2'd2,
        ERR_OVR  = 2'd3
    } pkt_err_t;

    // Expected checksum byte: ones' complement of the mod-256 sum of opcode and data bytes.
    function automatic logic [7:0] pkt_chk(input logic [7:0] sum);
        return ~sum;
    endfunction

endpackage

// File: rtl/uart_pkt_comm_if.sv
// uart_pkt_comm_if: serial lines plus the response and command handshakes of uart_pkt_comm.
interface uart_pkt_comm_if
    import uart_pkt_pkg::*;
#(
    parameter int DATA_BYTES = 2,
    parameter int ERR_CNT_W  = 8
);
    logic                    RX;
    logic                    TX;
    logic [7:0]              resp;
    logic                    send_resp;
    logic                    resp_sent;
    logic                    clr_cmd_rdy;
    logic                    cmd_rdy;
    logic [7:0]              cmd;
    logic [8*DATA_BYTES-1:0] data;
    logic                    cmd_err;
    pkt_err_t                err_code;
    logic [ERR_CNT_W-1:0]    err_cnt;

    modport master (
        output RX, resp, send_resp, clr_cmd_rdy,
        input  TX, resp_sent, cmd_rdy, cmd, data, cmd_err, err_code, err_cnt
    );

    modport slave (
        input  RX, resp, send_resp, clr_cmd_rdy,
        output TX, resp_sent, cmd_rdy, cmd, data, cmd_err, err_code, err_cnt
    );
endinterface

// File: rtl/uart_pkt_comm_uart.sv
// uart_pkt_comm_uart: 8N1 UART transceiver; rx_rdy holds until cleared, tx_done is a one-cycle pulse.
module uart_pkt_comm_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic [7:0] i_tx_data,
    input  logic       i_trmt,
    output logic       o_tx_done,
    output logic [7:0] o_rx_data,
    output logic       o_rx_rdy,
    input  logic       i_clr_rx_rdy
);
    localparam int             BW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  HALF     = BW'(CLKS_PER_BIT / 2);

    logic [1:0]    r_rx_sync;
    logic          r_rx_busy;
    logic [BW-1:0] r_rx_baud;
    logic [3:0]    r_rx_bits;
    logic [7:0]    r_rx_shift;
    logic          r_rx_rdy;
    logic          w_rx_sample;
    logic          w_rx_done;

    logic          r_tx_busy;
    logic [BW-1:0] r_tx_baud;
    logic [3:0]    r_tx_bits;
    logic [9:0]    r_tx_shift;
    logic          r_tx_done;

    assign w_rx_sample = r_rx_busy && (r_rx_baud == '0);
    assign w_rx_done   = w_rx_sample && (r_rx_bits == 4'd9);

    // Samples start, 8 data bits and stop at bit centres; the start bit falls off the 8-bit shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync  <= 2'b11;
            r_rx_busy  <= 1'b0;
            r_rx_baud  <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
            r_rx_rdy   <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], i_rx};
            if (!r_rx_busy) begin
                r_rx_busy <= !r_rx_sync[1];
                r_rx_baud <= HALF;
                r_rx_bits <= '0;
            end else if (w_rx_sample) begin
                if (!w_rx_done)
                    r_rx_shift <= {r_rx_sync[1], r_rx_shift[7:1]};
                r_rx_bits <= r_rx_bits + 1'b1;
                r_rx_baud <= BIT_LAST;
                r_rx_busy <= !w_rx_done;
            end else begin
                r_rx_baud <= r_rx_baud - 1'b1;
            end
            r_rx_rdy <= w_rx_done | (r_rx_rdy & ~i_clr_rx_rdy);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_busy  <= 1'b0;
            r_tx_baud  <= '0;
            r_tx_bits  <= '0;
            r_tx_shift <= '1;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (!r_tx_busy) begin
                if (i_trmt) begin
                    r_tx_busy  <= 1'b1;
                    r_tx_shift <= {1'b1, i_tx_data, 1'b0};
                    r_tx_baud  <= BIT_LAST;
                    r_tx_bits  <= '0;
                end
            end else if (r_tx_baud == '0) begin
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_baud  <= BIT_LAST;
                r_tx_bits  <= r_tx_bits + 1'b1;
                if (r_tx_bits == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_tx_done <= 1'b1;
                end
            end else begin
                r_tx_baud <= r_tx_baud - 1'b1;
            end
        end
    end

    assign o_rx_data = r_rx_shift;
    assign o_rx_rdy  = r_rx_rdy;
    assign o_tx      = r_tx_shift[0];
    assign o_tx_done = r_tx_done;
endmodule

// File: rtl/uart_pkt_comm.sv
// uart_pkt_comm: frames opcode + DATA_BYTES params (+ checksum) from the UART into double-buffered cmd/data,
// with inter-byte timeout resync, overrun detection and saturating error counting.
module uart_pkt_comm
    import uart_pkt_pkg::*;
#(
    parameter int DATA_BYTES   = 2,
    parameter int CHK_EN       = 1,
    parameter int TIMEOUT_CYC  = 50000,
    parameter int ERR_CNT_W    = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_pkt_comm_if.slave bus
);
    localparam int            DW        = 8 * DATA_BYTES;
    localparam int            TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(DATA_BYTES - 1);

    logic [7:0]           w_rx_data;
    logic                 w_rx_rdy;
    logic                 w_clr_rx_rdy;
    pkt_state_t           r_state;
    pkt_state_t           w_next_state;
    logic [1:0]           r_byte_cnt;
    logic [7:0]           r_stage_cmd;
    logic [7:0]           r_sum;
    logic [DW-1:0]        r_stage_data;
    logic [DW-1:0]        w_shift;
    logic [TW-1:0]        r_to_cnt;
    logic                 w_timeout;
    logic                 w_commit;
    logic                 w_err;
    pkt_err_t             w_err_code;
    logic                 r_cmd_rdy;
    logic                 r_cmd_err;
    logic [7:0]           r_cmd;
    logic [DW-1:0]        r_data;
    pkt_err_t             r_err_code;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    uart_pkt_comm_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (bus.RX),
        .o_tx        (bus.TX),
        .i_tx_data   (bus.resp),
        .i_trmt      (bus.send_resp),
        .o_tx_done   (bus.resp_sent),
        .o_rx_data   (w_rx_data),
        .o_rx_rdy    (w_rx_rdy),
        .i_clr_rx_rdy(w_clr_rx_rdy)
    );

    assign w_shift   = (r_stage_data << 8) | DW'(w_rx_data);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_state != IDLE) && !w_rx_rdy && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_clr_rx_rdy = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        w_err_code   = ERR_NONE;
        case (r_state)
            IDLE: if (w_rx_rdy) begin
                w_clr_rx_rdy = 1'b1;
                w_next_state = DATA;
            end
            DATA: if (w_rx_rdy) begin
                w_clr_rx_rdy = 1'b1;
                if (r_byte_cnt == LAST_BYTE) begin
                    if (CHK_EN != 0) begin
                        w_next_state = CHK;
                    end else begin
                        w_next_state = IDLE;
                        w_commit     = 1'b1;
                    end
                end
            end
            CHK: if (w_rx_rdy) begin
                w_clr_rx_rdy = 1'b1;
                w_next_state = IDLE;
                w_commit     = (w_rx_data == pkt_chk(r_sum));
                w_err        = !w_commit;
                w_err_code   = w_commit ? ERR_NONE : ERR_CHK;
            end
            default: w_next_state = IDLE;
        endcase
        if (w_timeout) begin
            w_next_state = IDLE;
            w_err        = 1'b1;
            w_err_code   = ERR_TO;
        end
        if (w_commit && r_cmd_rdy && !bus.clr_cmd_rdy) begin
            w_err      = 1'b1;
            w_err_code = ERR_OVR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt   <= '0;
            r_stage_cmd  <= '0;
            r_stage_data <= '0;
            r_sum        <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_to_cnt <= (r_state == IDLE || w_rx_rdy || w_timeout) ? '0 : r_to_cnt + 1'b1;
            if (w_rx_rdy && r_state == IDLE) begin
                r_stage_cmd <= w_rx_data;
                r_sum       <= w_rx_data;
                r_byte_cnt  <= '0;
            end else if (w_rx_rdy && r_state == DATA) begin
                r_stage_data <= w_shift;
                r_sum        <= r_sum + w_rx_data;
                r_byte_cnt   <= r_byte_cnt + 1'b1;
            end
        end
    end

    // Without a checksum the final data byte commits straight from the shifter input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_rdy  <= 1'b0;
            r_cmd      <= '0;
            r_data     <= '0;
            r_cmd_err  <= 1'b0;
            r_err_code <= ERR_NONE;
            r_err_cnt  <= '0;
        end else begin
            r_cmd_err <= w_err;
            r_cmd_rdy <= w_commit | (r_cmd_rdy & ~bus.clr_cmd_rdy);
            if (w_commit) begin
                r_cmd  <= r_stage_cmd;
                r_data <= (r_state == CHK) ? r_stage_data : w_shift;
            end
            if (w_err) begin
                r_err_code <= w_err_code;
                r_err_cnt  <= (&r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;
            end
        end
    end

    assign bus.cmd_rdy  = r_cmd_rdy;
    assign bus.cmd      = r_cmd;
    assign bus.data     = r_data;
    assign bus.cmd_err  = r_cmd_err;
    assign bus.err_code = r_err_code;
    assign bus.err_cnt  = r_err_cnt;
endmodule
